// File: rtl/matmul_pkg.sv
// Shared constants, widths and scheduler state encoding for the matmul job sequencer.
package matmul_pkg;

  localparam int unsigned MAX_ELEMENT_SIZE = 8;
  localparam int unsigned MAX_SIZE_A       = 32;
  localparam int unsigned MAX_SIZE_B       = 32;
  localparam int unsigned ACC_W            = 2 * MAX_ELEMENT_SIZE + $clog2(MAX_SIZE_A);

  localparam int unsigned ROW_W  = $clog2(MAX_SIZE_A);
  localparam int unsigned COL_W  = $clog2(MAX_SIZE_B);
  localparam int unsigned DIMA_W = ROW_W + 1;
  localparam int unsigned DIMB_W = COL_W + 1;
  localparam int unsigned VEC_W  = MAX_SIZE_A * MAX_ELEMENT_SIZE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    MAC  = 3'd3,
    EMIT = 3'd4,
    FIN  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/dot_product_mac.sv
// Serial dot-product accumulator: one a[k]*b[k] product added per step.
module dot_product_mac
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [ROW_W-1:0] i_k,
  input  logic [VEC_W-1:0] i_a_vec,
  input  logic [VEC_W-1:0] i_b_vec,
  output logic [ACC_W-1:0] o_acc
);

  logic [MAX_ELEMENT_SIZE-1:0] w_a;
  logic [MAX_ELEMENT_SIZE-1:0] w_b;
  logic [ACC_W-1:0]            w_prod;
  logic [ACC_W-1:0]            r_acc;

  assign w_a    = i_a_vec[i_k * MAX_ELEMENT_SIZE +: MAX_ELEMENT_SIZE];
  assign w_b    = i_b_vec[i_k * MAX_ELEMENT_SIZE +: MAX_ELEMENT_SIZE];
  assign w_prod = ACC_W'(w_a) * ACC_W'(w_b);

  // Accumulator: clear wins over step so a fresh operand pair always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/matmul_scheduler.sv
// Sequences one C = A x B job: requests each (row, col) operand pair, MACs it, hands C[row][col] on.
module matmul_scheduler
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIMA_W-1:0] num_rows_a,
  input  logic [DIMA_W-1:0] num_inner,
  input  logic [DIMB_W-1:0] num_cols_b,
  output logic              busy,
  output logic              req_valid,
  output logic [ROW_W-1:0]  req_a_row,
  output logic [COL_W-1:0]  req_b_col,
  input  logic              req_ready,
  input  logic              ld_valid,
  input  logic [ROW_W-1:0]  ld_a_addr,
  input  logic [COL_W-1:0]  ld_b_addr,
  input  logic [VEC_W-1:0]  ld_a_row,
  input  logic [VEC_W-1:0]  ld_b_col,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ROW_W-1:0]  res_row,
  output logic [COL_W-1:0]  res_col,
  output logic [ACC_W-1:0]  res_data,
  output logic              done
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [DIMA_W-1:0] r_rows;
  logic [DIMA_W-1:0] r_inner;
  logic [DIMB_W-1:0] r_cols;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_k;
  logic [VEC_W-1:0]  r_a_vec;
  logic [VEC_W-1:0]  r_b_vec;
  logic              r_busy;
  logic              r_req_valid;
  logic              r_res_valid;
  logic              r_done;

  logic [DIMA_W-1:0] w_rows_clamp;
  logic [DIMA_W-1:0] w_inner_clamp;
  logic [DIMB_W-1:0] w_cols_clamp;
  logic              w_zero_dim;
  logic              w_ld_hit;
  logic              w_last_k;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_clear;
  logic              w_step;
  logic [ACC_W-1:0]  w_acc;

  assign w_rows_clamp  = (num_rows_a > DIMA_W'(MAX_SIZE_A)) ? DIMA_W'(MAX_SIZE_A) : num_rows_a;
  assign w_inner_clamp = (num_inner  > DIMA_W'(MAX_SIZE_A)) ? DIMA_W'(MAX_SIZE_A) : num_inner;
  assign w_cols_clamp  = (num_cols_b > DIMB_W'(MAX_SIZE_B)) ? DIMB_W'(MAX_SIZE_B) : num_cols_b;
  assign w_zero_dim    = (num_rows_a == '0) || (num_inner == '0) || (num_cols_b == '0);

  // Only the operand pair for the outstanding request is accepted; anything else is stale.
  assign w_ld_hit   = ld_valid && (ld_a_addr == r_row) && (ld_b_addr == r_col);
  assign w_last_k   = ({1'b0, r_k}   == (r_inner - DIMA_W'(1)));
  assign w_last_col = ({1'b0, r_col} == (r_cols  - DIMB_W'(1)));
  assign w_last_row = ({1'b0, r_row} == (r_rows  - DIMA_W'(1)));

  // Next-state decode plus MAC control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = w_zero_dim ? FIN : REQ;
      REQ:  if (req_ready) w_state_nxt = WAIT;
      WAIT: begin
        if (w_ld_hit) begin
          w_clear     = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_step = 1'b1;
        if (w_last_k) w_state_nxt = EMIT;
      end
      EMIT: if (res_ready) w_state_nxt = (w_last_col && w_last_row) ? FIN : REQ;
      FIN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Job dimensions, pair/k counters, operand capture and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows      <= '0;
      r_inner     <= '0;
      r_cols      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_a_vec     <= '0;
      r_b_vec     <= '0;
      r_busy      <= 1'b0;
      r_req_valid <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_rows  <= w_rows_clamp;
        r_inner <= w_inner_clamp;
        r_cols  <= w_cols_clamp;
        r_row   <= '0;
        r_col   <= '0;
      end
      if (w_clear) begin
        r_a_vec <= ld_a_row;
        r_b_vec <= ld_b_col;
        r_k     <= '0;
      end else if (w_step) begin
        r_k <= r_k + ROW_W'(1);
      end
      if ((r_state == EMIT) && res_ready) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      r_busy      <= (w_state_nxt != IDLE);
      r_req_valid <= (w_state_nxt == REQ);
      r_res_valid <= (w_state_nxt == EMIT);
      r_done      <= (w_state_nxt == FIN);
    end
  end

  dot_product_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_step  (w_step),
    .i_k     (r_k),
    .i_a_vec (r_a_vec),
    .i_b_vec (r_b_vec),
    .o_acc   (w_acc)
  );

  assign busy      = r_busy;
  assign req_valid = r_req_valid;
  assign req_a_row = r_row;
  assign req_b_col = r_col;
  assign res_valid = r_res_valid;
  assign res_row   = r_row;
  assign res_col   = r_col;
  assign res_data  = w_acc;
  assign done      = r_done;

endmodule
